// File: rtl/seg_scan_pkg.sv
// Shared definitions for the 4-digit multiplexed seven-segment scanner.
// Holds FSM encoding, the active-low hex glyph table and the blank constants.
package seg_scan_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    localparam logic [3:0] AN_OFF  = 4'b1111;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Index n holds the {g,f,e,d,c,b,a} active-low glyph for hex digit n.
    localparam logic [15:0][6:0] HEX_TAB = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,   // F E d C
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,   // b A 9 8
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,   // 7 6 5 4
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000    // 3 2 1 0
    };

endpackage

// File: rtl/seg_scan_hex7seg.sv
// Combinational hex nibble to active-low seven-segment glyph decode.
// Zero latency; no flow control.
module hex7seg
    import seg_scan_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] pat
);

    assign pat = HEX_TAB[nib];

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexes addr/led_data as four hex digits with a blanking guard per slot.
// Outputs are registered and follow the slot/digit registers on the same edge; en=0 freezes the scan.
module seg_scan
    import seg_scan_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] addr,
    input  logic [7:0] led_data,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int            CW       = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK_CYC);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    dig, dig_nxt;
    logic [7:0]    snap_addr, snap_addr_nxt;
    logic [7:0]    snap_data, snap_data_nxt;
    state_t        state, state_nxt;
    logic          wrap;
    logic [3:0]    nib;
    logic [6:0]    pat;

    // Outputs are decoded from next-state values so they land on the same edge as the state.
    always_comb begin
        wrap          = en && (cnt == CNT_LAST);
        cnt_nxt       = cnt;
        dig_nxt       = dig;
        snap_addr_nxt = snap_addr;
        snap_data_nxt = snap_data;
        state_nxt     = state;
        if (en) begin
            cnt_nxt = wrap ? '0 : cnt + CNT_ONE;
            if (wrap) begin
                dig_nxt = dig + 2'd1;
            end
            // Snapshot only at frame boundary so a whole frame shows one coherent value.
            if (wrap && (dig == 2'd3)) begin
                snap_addr_nxt = addr;
                snap_data_nxt = led_data;
            end
            state_nxt = (cnt_nxt < CNT_SHOW) ? ST_BLANK : ST_SHOW;
        end
        case (dig_nxt)
            2'd3:    nib = snap_addr_nxt[7:4];
            2'd2:    nib = snap_addr_nxt[3:0];
            2'd1:    nib = snap_data_nxt[7:4];
            default: nib = snap_data_nxt[3:0];
        endcase
    end

    hex7seg u_hex7seg (
        .nib (nib),
        .pat (pat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            dig       <= 2'd0;
            state     <= ST_BLANK;
            snap_addr <= 8'h00;
            snap_data <= 8'h00;
            an        <= AN_OFF;
            seg       <= SEG_OFF;
            dp        <= 1'b1;
        end else begin
            cnt       <= cnt_nxt;
            dig       <= dig_nxt;
            state     <= state_nxt;
            snap_addr <= snap_addr_nxt;
            snap_data <= snap_data_nxt;
            if (en && (state_nxt == ST_SHOW)) begin
                an  <= ~(4'b0001 << dig_nxt);
                seg <= pat;
                dp  <= (dig_nxt != 2'd2);
            end else begin
                an  <= AN_OFF;
                seg <= SEG_OFF;
                dp  <= 1'b1;
            end
        end
    end

endmodule
